// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie and last_owner is not built.
module dmem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rsp_valid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    localparam int unsigned MEM_AW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   any_req_c;
    logic   pick1_c;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 has absolute priority on a tie.
    always_comb begin
        any_req_c = req0 | req1;
        pick1_c   = req1 & ~req0;
    end
`else
    logic last_owner;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        any_req_c = req0 | req1;
        pick1_c   = req1 & (~req0 | ~last_owner);
    end
`endif

    // Sequencer: the mem_* registers double as the latched request while ACCESS lasts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_owner <= 1'b1;
`endif
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_rdata  <= '0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            busy       <= 1'b0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        owner      <= pick1_c;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_owner <= pick1_c;
`endif
                        gnt0       <= ~pick1_c;
                        gnt1       <= pick1_c;
                        mem_we     <= pick1_c ? we1 : we0;
                        mem_a      <= pick1_c ? MEM_AW'(addr1) : MEM_AW'(addr0);
                        mem_wd     <= pick1_c ? wdata1 : wdata0;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // For a write this captures the pre-write word.
                    rsp_rdata  <= mem_rd;
                    rsp_valid0 <= ~owner;
                    rsp_valid1 <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural 1024x32 data memory.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, mem_we, busy;
    logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [1024];
    logic        load_en = 1'b0;
    logic [9:0]  load_a = '0;
    logic [31:0] load_d = '0;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rsp_valid0(rsp_valid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rsp_valid1(rsp_valid1),
        .rsp_rdata(rsp_rdata), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) mem[load_a] <= load_d;
        else if (mem_we) mem[mem_a[9:0]] <= mem_wd;
    end

    assign mem_rd = (mem_a[31:10] == 22'd0) ? mem[mem_a[9:0]] : 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // The only write that should reach the memory is the one to word 5.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            chk("write_addr", mem_a, 32'd5);
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [5:0]  flags;   // {gnt0,gnt1,rsp_valid0,rsp_valid1,busy,mem_we}
        logic [31:0] ea;
        logic        chk_rd;
        logic [31:0] erd;
    } vec_t;

    localparam logic [5:0] F_IDLE = 6'b000000;
    localparam logic [5:0] F_G0   = 6'b100010;
    localparam logic [5:0] F_G1   = 6'b010010;
    localparam logic [5:0] F_G1W  = 6'b010011;
    localparam logic [5:0] F_V0   = 6'b001010;
    localparam logic [5:0] F_V1   = 6'b000110;
    localparam int NV = 30;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [9:0] a0,
                                input logic [31:0] d0, input logic r1, input logic w1,
                                input logic [9:0] a1, input logic [31:0] d1,
                                input logic [5:0] flags, input logic [31:0] ea,
                                input logic chk_rd, input logic [31:0] erd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.flags = flags; v.ea = ea; v.chk_rd = chk_rd; v.erd = erd;
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        load_a  = a;
        load_d  = d;
        load_en = 1'b1;
        step();
        load_en = 1'b0;
    endtask

    vec_t vecs [NV];

    initial begin
        logic p;
        // Single read, write then read-back.
        vecs[0] = mk(1, 0, 28, 0, 0, 0, 0, 0, F_G0, 28, 0, 0);
        vecs[1] = mk(1, 0, 28, 0, 0, 0, 0, 0, F_V0, 28, 1, 32'h0000_0020);
        vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 28, 0, 0);
        vecs[3] = mk(0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF, F_G1W, 5, 0, 0);
        vecs[4] = mk(0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF, F_V1, 5, 1, 32'h5555_5555);
        vecs[5] = mk(0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF, F_IDLE, 5, 0, 0);
        vecs[6] = mk(0, 0, 0, 0, 1, 0, 5, 0, F_G1, 5, 0, 0);
        vecs[7] = mk(0, 0, 0, 0, 1, 0, 5, 0, F_V1, 5, 1, 32'hDEAD_BEEF);
        vecs[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 5, 0, 0);
        // Continuous tie: alternating in round-robin, port 0 only when fixed.
        for (int k = 0; k < 4; k++) begin
            p = FIXED ? 1'b0 : k[0];
            vecs[9 + 3*k]  = mk(1, 0, 28, 0, 1, 0, 40, 0, p ? F_G1 : F_G0, p ? 32'd40 : 32'd28, 0, 0);
            vecs[10 + 3*k] = mk(1, 0, 28, 0, 1, 0, 40, 0, p ? F_V1 : F_V0, p ? 32'd40 : 32'd28,
                                1, p ? 32'h2 : 32'h20);
            vecs[11 + 3*k] = mk(1, 0, 28, 0, 1, 0, 40, 0, F_IDLE, p ? 32'd40 : 32'd28, 0, 0);
        end
        // Lone requester, then request inputs changing after grant.
        vecs[21] = mk(0, 0, 0, 0, 1, 0, 40, 0, F_G1, 40, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 1, 0, 40, 0, F_V1, 40, 1, 32'h2);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 40, 0, 0);
        vecs[24] = mk(1, 0, 40, 0, 0, 0, 0, 0, F_G0, 40, 0, 0);
        vecs[25] = mk(1, 1, 28, 32'hFFFF_FFFF, 0, 0, 0, 0, F_V0, 40, 1, 32'h2);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 40, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 1, 0, 40, 0, F_G1, 40, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 0, 40, 0, F_V1, 40, 1, 32'h2);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 40, 0, 0);

        #1 rst = 1'b0;
        #1;
        chk("reset_flags", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we}), 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wd", mem_wd, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);

        preload(10'd28, 32'h0000_0020);
        preload(10'd40, 32'h0000_0002);
        preload(10'd7,  32'hCAFE_0007);
        preload(10'd5,  32'h5555_5555);
        step();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
            req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
            step();
            chk($sformatf("v%0d_flags", i),
                32'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we}), 32'(vecs[i].flags));
            chk($sformatf("v%0d_mem_a", i), mem_a, vecs[i].ea);
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].erd);
        end
        chk("write_pulses", 32'(we_cnt), 32'd1);

        // Reset asserted during a write access.
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd7; wdata0 = 32'h0000_1234;
        step();
        chk("rw_gnt_we", 32'({gnt0, mem_we}), 32'b11);
        chk("rw_mem_a", mem_a, 32'd7);
        #2 rst = 1'b0;
        #1;
        chk("rw_async_flags", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we}), 32'd0);
        chk("rw_async_mem_a", mem_a, 32'd0);
        chk("rw_async_mem_wd", mem_wd, 32'd0);
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rw_in_reset_valid", 32'({rsp_valid0, rsp_valid1, busy}), 32'd0);
        end
        rst = 1'b1;
        step();
        chk("rw_released_idle", 32'({rsp_valid0, rsp_valid1, busy, mem_we}), 32'd0);
        chk("rw_word7_kept", mem[7], 32'hCAFE_0007);

        // First tie after reset goes to port 0 in both builds.
        req0 = 1'b1; addr0 = 10'd7; req1 = 1'b1; addr1 = 10'd28;
        step();
        chk("post_rst_flags", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we}), 32'(F_G0));
        chk("post_rst_mem_a", mem_a, 32'd7);
        step();
        chk("post_rst_rsp", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we}), 32'(F_V0));
        chk("post_rst_rdata", rsp_rdata, 32'hCAFE_0007);
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("post_rst_idle", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we}), 32'd0);
        chk("write_pulses_final", 32'(we_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (`data_mem`: 1024 x 32, synchronous write, combinational read).
- Port 0 is the core load/store unit; port 1 is the debug/loader port.
- Accepts one request at a time, drives the memory for exactly one access cycle, and returns the read data with a one-cycle response pulse.

Parameters:
- DATA_W, 32, data width of requester, memory and response buses.
- ADDR_W, 10, word-address width on the requester ports; zero-extended to 32 bits on mem_a.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until rsp_valid0.
- we0  in  1  port 0 write enable (1 = write, 0 = read); stable while req0 is high.
- addr0  in  ADDR_W  port 0 word address; stable while req0 is high.
- wdata0  in  DATA_W  port 0 write data; stable while req0 is high.
- gnt0  out  1  one-cycle pulse: port 0 request accepted.
- rsp_valid0  out  1  one-cycle pulse: port 0 access complete.
- req1/we1/addr1/wdata1/gnt1/rsp_valid1  same as port 0, for port 1.
- rsp_rdata  out  DATA_W  registered read data, shared by both ports; valid while either rsp_valid is high.
- mem_we  out  1  memory write enable.
- mem_a  out  32  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data (combinational).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE, which waits for a request.
- IDLE:
  - Samples req0/req1 at each rising edge.
  - If any request is high: latch owner, we, addr, wdata into internal registers, set gnt[owner]=1, go to ACCESS.
- ACCESS:
  - mem_a = zero-extended latched addr; mem_wd = latched wdata; mem_we = latched we.
  - The write commits at the rising edge that ends ACCESS.
  - At that same edge, capture rsp_rdata <= mem_rd for both reads and writes. For a write this is the pre-write value, since the read is combinational.
  - Go to RESP.
- RESP: rsp_valid[owner]=1; go to IDLE.
- Outside ACCESS: mem_we=0; mem_a and mem_wd hold their last driven values.
- Latency:
  - req high before edge k -> gnt high in cycle k, memory access in cycle k, rsp_valid high in cycle k+1.
  - Maximum throughput: one access per 3 cycles.
- Request/response protocol:
  - Requester must drop req, or present a new request, in the cycle after rsp_valid.
  - A req still high in IDLE is treated as a new request.
- Arbitration is round-robin on ties.
  - Register last_owner is updated on each grant; reset value is 1, so port 0 wins the first tie.
  - On a tie, the port != last_owner wins.
  - A single requester is always granted, regardless of last_owner.
- Request changes after acceptance: req, we, addr and wdata changing after gnt do not affect the in-flight access (everything is latched at grant).
- Reset values: gnt0=gnt1=0, rsp_valid0=rsp_valid1=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0, busy=0, state=IDLE, last_owner=1.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately (asynchronous).
  - A write in ACCESS is not committed unless its rising edge preceded reset assertion.
  - No rsp_valid is issued for an aborted transaction.
- Reset release: the first arbitration happens at the first rising edge with rst=1.
- Never more than one gnt or rsp_valid high in the same cycle.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins a tie; last_owner is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then single read: rst low 2 cycles then high; preload word 28 = 0x00000020; req0 read addr 28 -> gnt0 in cycle k, rsp_valid0 in cycle k+1 with rsp_rdata = 0x00000020, mem_we never high.
- Write then read-back: req1 write addr 5, wdata 0xDEADBEEF, then req1 read addr 5 -> second rsp_rdata = 0xDEADBEEF; mem_we high for exactly 1 cycle, with mem_a = 5.
- Round-robin tie: req0 and req1 held continuously, both reads (addr 28 and 40) -> grant order 0,1,0,1; rsp_rdata alternates 0x20 / 0x02; one rsp_valid every 3 cycles.
- Fixed-priority build (DMEM_ARB_FIXED_PRIO_EN defined): same stimulus as the tie test -> port 0 granted every time; port 1 granted only after req0 drops.
- Reset mid-write: req0 write addr 7, wdata 0x1234; rst asserted during ACCESS before the clock edge -> mem_we=0 immediately, word 7 unchanged, no rsp_valid0, state IDLE after release.
- Input change after grant: after gnt0, change addr0 from 40 to 28 -> access still uses addr 40; rsp_rdata = 0x00000002.
